mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Pipeline stage between the execute unit and the writeback unit.
- Accepts one instruction at a time from execute over a valid/ready handshake.
- Performs the load or store on a single-outstanding memory bus.
- Presents the result to writeback over the valid/ready interface that writeback consumes: MEM_Rdata, Ex_result, csrs, pc, rd, csr_wen, R_wen, mem_ren, jump_flag, inst.

Parameters:
- TIMEOUT, 255: maximum cycles WAIT may last before a bus error is declared. Legal range 1..255.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  execute result valid
- in_ready  out  1  stage can accept
- ex_result  in  32  ALU result / memory address
- ex_wdata  in  32  store data (rs2)
- ex_funct3  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
- ex_mem_ren, ex_mem_wen  in  1 each  load / store
- ex_csrs  in  32  CSR read value (pass-through)
- ex_pc, ex_inst  in  32 each  pass-through
- ex_rd  in  5  pass-through
- ex_csr_wen  in  4  pass-through
- ex_R_wen, ex_jump_flag  in  1 each  pass-through
- mem_req  out  1  bus request
- mem_we  out  1  store request
- mem_addr  out  32  word-aligned address ({ex_result[31:2],2'b00})
- mem_wdata  out  32  lane-shifted store data
- mem_wmask  out  4  byte strobes
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  response (load data or store ack)
- mem_rdata  in  32  raw load word
- out_valid  out  1  valid to writeback
- out_ready  in  1  writeback ready
- MEM_Rdata  out  32  extended load data
- Ex_result, csrs, pc, inst  out  32 each  registered pass-through
- rd  out  5  registered pass-through
- csr_wen  out  4  registered pass-through
- R_wen, mem_ren, jump_flag  out  1 each  registered pass-through
- bus_err  out  1  timeout or misaligned access for this instruction

Behaviour:
- Reset is synchronous and active-high (reset), clocked by clock.
- On reset:
  - state=IDLE.
  - out_valid, mem_req, mem_we, bus_err = 0.
  - All registered outputs and mem_addr/wdata/wmask = 0.
  - Timeout counter = 0.
- Reset asserted mid-transaction abandons it: mem_req drops the cycle after reset is sampled.
- FSM states: IDLE, REQ, WAIT, OUT. in_ready = (state==IDLE).
- IDLE:
  - On in_valid&in_ready, latch all ex_* fields.
  - Misaligned access (h with addr[0]=1, w with addr[1:0]!=0) with ren|wen: no bus access, bus_err=1, MEM_Rdata=0, go to OUT.
  - Otherwise, if ren|wen: go to REQ. Else: go to OUT.
- REQ:
  - mem_req=1. mem_we=wen. Outputs are held stable until mem_gnt.
  - mem_gnt=1: go to WAIT next cycle and clear the counter.
  - mem_gnt and mem_rvalid in the same cycle: both are honoured (go to OUT, data captured).
- WAIT:
  - mem_req=0. Counter increments each cycle.
  - On mem_rvalid, capture the extended rdata (store: MEM_Rdata=0) and go to OUT.
  - If counter reaches TIMEOUT without mem_rvalid: bus_err=1, MEM_Rdata=0, go to OUT.
- OUT:
  - out_valid=1; all outputs held stable until out_ready.
  - On out_valid&out_ready, go to IDLE next cycle.
  - The next instruction is accepted the following cycle; no bypass.
- mem_rvalid outside REQ/WAIT is ignored.
- Both ren and wen high: treated as a store; mem_ren output forced 0.
- Store lanes (o = addr[1:0]):
  - b: wmask = 4'b0001<<o; wdata = {4{wdata[7:0]}}.
  - h: wmask = 4'b0011<<o; wdata = {2{wdata[15:0]}}.
  - w: wmask = 4'b1111; wdata unchanged.
- Load extract: select byte/half at offset o from mem_rdata; sign-extend for 000/001, zero-extend for 100/101, full word for 010.
- Latency (accept edge N):
  - Non-memory: out_valid at N+1.
  - Load with gnt at N+1 and rvalid at N+2: out_valid at N+3.

Test Plan:
- ALU op ex_result=32'h1234, out_ready=1 -> out_valid one cycle after accept; Ex_result=32'h1234; mem_req never asserted; back to in_ready the next cycle.
- lb addr=32'h8000_0003, mem_rdata=32'h80FF_0000, gnt immediate, rvalid +1 -> mem_addr=32'h8000_0000, MEM_Rdata=32'hFFFF_FF80; lbu same -> 32'h0000_0080.
- sh addr=32'h8000_0002, ex_wdata=32'hABCD_5678 -> mem_wmask=4'b1100, mem_wdata=32'h5678_5678, mem_we=1; MEM_Rdata=0 after ack.
- mem_gnt held low 5 cycles, out_ready low 3 cycles in OUT -> mem_req and all mem_*/out signals stable throughout; in_ready=0 throughout.
- lw addr=32'h8000_0002 -> no mem_req, bus_err=1, out_valid next cycle; separately, TIMEOUT=4 with no rvalid -> bus_err=1 after 4 WAIT cycles.
- reset asserted during WAIT, then a stray mem_rvalid -> state IDLE, out_valid=0, stray response ignored, next instruction processed correctly.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: load/store stage between execute and writeback on a single-outstanding bus.
// One instruction is in flight at a time; every writeback output is registered and held until consumed.
module mem_access_stage #(
   parameter int TIMEOUT = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] ex_result,
   input  logic [31:0] ex_wdata,
   input  logic [2:0]  ex_funct3,
   input  logic        ex_mem_ren,
   input  logic        ex_mem_wen,
   input  logic [31:0] ex_csrs,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_inst,
   input  logic [4:0]  ex_rd,
   input  logic [3:0]  ex_csr_wen,
   input  logic        ex_R_wen,
   input  logic        ex_jump_flag,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] MEM_Rdata,
   output logic [31:0] Ex_result,
   output logic [31:0] csrs,
   output logic [31:0] pc,
   output logic [31:0] inst,
   output logic [4:0]  rd,
   output logic [3:0]  csr_wen,
   output logic        R_wen,
   output logic        mem_ren,
   output logic        jump_flag,
   output logic        bus_err
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;
   typedef struct packed {
      logic [31:0] result;
      logic [31:0] csrs;
      logic [31:0] pc;
      logic [31:0] inst;
      logic [4:0]  rd;
      logic [3:0]  csr_wen;
      logic [2:0]  funct3;
      logic        r_wen;
      logic        ren;
      logic        wen;
      logic        jump;
   } ctx_t;
   localparam logic [7:0] TO = 8'(TIMEOUT);
   state_t      state_q, state_d;
   ctx_t        ctx_q, ctx_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic [31:0] wdata_in, shifted, load_val;
   logic [3:0]  wmask_q, wmask_d, wmask_in;
   logic [7:0]  cnt_q, cnt_d;
   logic        err_q, err_d, access, misaligned;
   logic [1:0]  sz;
   assign sz = ex_funct3[1:0];
   assign access = ex_mem_ren | ex_mem_wen;
   assign misaligned = (sz == 2'b01 && ex_result[0]) || (sz == 2'b10 && ex_result[1:0] != 2'b00);
   // Store lanes: narrow data is replicated so the strobe picks the right copy.
   assign wmask_in = !ex_mem_wen ? 4'b0000 :
                     sz == 2'b00 ? 4'b0001 << ex_result[1:0] :
                     sz == 2'b01 ? 4'b0011 << ex_result[1:0] : 4'b1111;
   assign wdata_in = sz == 2'b00 ? {4{ex_wdata[7:0]}} :
                     sz == 2'b01 ? {2{ex_wdata[15:0]}} : ex_wdata;
   assign shifted = mem_rdata >> {ctx_q.result[1:0], 3'b000};
   assign load_val = ctx_q.wen ? 32'd0 :
                     ctx_q.funct3 == 3'b000 ? {{24{shifted[7]}}, shifted[7:0]} :
                     ctx_q.funct3 == 3'b001 ? {{16{shifted[15]}}, shifted[15:0]} :
                     ctx_q.funct3 == 3'b100 ? {24'd0, shifted[7:0]} :
                     ctx_q.funct3 == 3'b101 ? {16'd0, shifted[15:0]} : shifted;
   always_comb begin
      state_d = state_q;
      ctx_d = ctx_q;
      addr_d = addr_q;
      wdata_d = wdata_q;
      wmask_d = wmask_q;
      rdata_d = rdata_q;
      err_d = err_q;
      cnt_d = cnt_q;
      case (state_q)
         IDLE: if (in_valid) begin
            ctx_d = '{result: ex_result, csrs: ex_csrs, pc: ex_pc, inst: ex_inst, rd: ex_rd,
                      csr_wen: ex_csr_wen, funct3: ex_funct3, r_wen: ex_R_wen,
                      ren: ex_mem_ren & ~ex_mem_wen, wen: ex_mem_wen, jump: ex_jump_flag};
            addr_d = {ex_result[31:2], 2'b00};
            wdata_d = wdata_in;
            wmask_d = wmask_in;
            rdata_d = 32'd0;
            err_d = access & misaligned;
            state_d = access && !misaligned ? REQ : OUT;
         end
         REQ: if (mem_gnt) begin
            cnt_d = 8'd0;
            rdata_d = mem_rvalid ? load_val : rdata_q;
            state_d = mem_rvalid ? OUT : WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q + 8'd1;
            if (mem_rvalid) begin
               rdata_d = load_val;
               state_d = OUT;
            end else if (cnt_q + 8'd1 == TO) begin
               err_d = 1'b1;
               rdata_d = 32'd0;
               state_d = OUT;
            end
         end
         OUT: state_d = out_ready ? IDLE : OUT;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         ctx_q <= '0;
         addr_q <= 32'd0;
         wdata_q <= 32'd0;
         wmask_q <= 4'd0;
         rdata_q <= 32'd0;
         err_q <= 1'b0;
         cnt_q <= 8'd0;
      end else begin
         state_q <= state_d;
         ctx_q <= ctx_d;
         addr_q <= addr_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
         rdata_q <= rdata_d;
         err_q <= err_d;
         cnt_q <= cnt_d;
      end
   end
   assign in_ready = state_q == IDLE;
   assign out_valid = state_q == OUT;
   assign mem_req = state_q == REQ;
   assign mem_we = state_q == REQ && ctx_q.wen;
   assign mem_addr = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_wmask = wmask_q;
   assign MEM_Rdata = rdata_q;
   assign Ex_result = ctx_q.result;
   assign csrs = ctx_q.csrs;
   assign pc = ctx_q.pc;
   assign inst = ctx_q.inst;
   assign rd = ctx_q.rd;
   assign csr_wen = ctx_q.csr_wen;
   assign R_wen = ctx_q.r_wen;
   assign mem_ren = ctx_q.ren;
   assign jump_flag = ctx_q.jump;
   assign bus_err = err_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed checks of handshakes, lane handling, misalignment, timeout and reset.
module tb_mem_access_stage;
   logic        clock = 1'b0, reset = 1'b1;
   logic        in_valid = 1'b0, in_ready;
   logic [31:0] ex_result = '0, ex_wdata = '0, ex_csrs = '0, ex_pc = '0, ex_inst = '0;
   logic [2:0]  ex_funct3 = '0;
   logic        ex_mem_ren = 1'b0, ex_mem_wen = 1'b0, ex_R_wen = 1'b0, ex_jump_flag = 1'b0;
   logic [4:0]  ex_rd = '0;
   logic [3:0]  ex_csr_wen = '0;
   logic        mem_req, mem_we, mem_gnt = 1'b0, mem_rvalid = 1'b0;
   logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
   logic [3:0]  mem_wmask;
   logic        out_valid, out_ready = 1'b0;
   logic [31:0] MEM_Rdata, Ex_result, csrs, pc, inst;
   logic [4:0]  rd;
   logic [3:0]  csr_wen;
   logic        R_wen, mem_ren, jump_flag, bus_err;
   int tests = 0, failed = 0;
   mem_access_stage #(.TIMEOUT(4)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .ex_result(ex_result), .ex_wdata(ex_wdata), .ex_funct3(ex_funct3),
      .ex_mem_ren(ex_mem_ren), .ex_mem_wen(ex_mem_wen), .ex_csrs(ex_csrs), .ex_pc(ex_pc),
      .ex_inst(ex_inst), .ex_rd(ex_rd), .ex_csr_wen(ex_csr_wen), .ex_R_wen(ex_R_wen),
      .ex_jump_flag(ex_jump_flag), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready), .MEM_Rdata(MEM_Rdata),
      .Ex_result(Ex_result), .csrs(csrs), .pc(pc), .inst(inst), .rd(rd), .csr_wen(csr_wen),
      .R_wen(R_wen), .mem_ren(mem_ren), .jump_flag(jump_flag), .bus_err(bus_err)
   );
   always #5 clock = ~clock;
   task automatic tick();
      @(posedge clock);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic send(input logic [31:0] a, input logic [31:0] w, input logic [2:0] f,
                       input logic r, input logic wr);
      ex_result = a;
      ex_wdata = w;
      ex_funct3 = f;
      ex_mem_ren = r;
      ex_mem_wen = wr;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask
   task automatic mem_txn(input logic [31:0] data);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata = data;
      tick();
      mem_rvalid = 1'b0;
   endtask
   initial begin
      tick();
      tick();
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_bus_err", 32'(bus_err), 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_wmask", 32'(mem_wmask), 32'd0);
      chk("rst_ex_result", Ex_result, 32'd0);
      reset = 1'b0;
      // ALU op with pass-through fields
      ex_pc = 32'h0000_0100;
      ex_inst = 32'h0000_0033;
      ex_csrs = 32'hCAFE_0001;
      ex_rd = 5'd5;
      ex_csr_wen = 4'h3;
      ex_R_wen = 1'b1;
      ex_jump_flag = 1'b1;
      out_ready = 1'b1;
      send(32'h1234, 32'h0, 3'b000, 1'b0, 1'b0);
      chk("alu_out_valid", 32'(out_valid), 32'd1);
      chk("alu_in_ready", 32'(in_ready), 32'd0);
      chk("alu_mem_req", 32'(mem_req), 32'd0);
      chk("alu_ex_result", Ex_result, 32'h1234);
      chk("alu_pc", pc, 32'h100);
      chk("alu_inst", inst, 32'h33);
      chk("alu_csrs", csrs, 32'hCAFE_0001);
      chk("alu_rd", 32'(rd), 32'd5);
      chk("alu_csr_wen", 32'(csr_wen), 32'd3);
      chk("alu_flags", {29'd0, R_wen, jump_flag, mem_ren}, 32'b110);
      tick();
      chk("alu_back_idle", 32'(in_ready), 32'd1);
      chk("alu_out_drop", 32'(out_valid), 32'd0);
      ex_R_wen = 1'b0;
      ex_jump_flag = 1'b0;
      // lb / lbu at byte 3
      send(32'h8000_0003, 32'h0, 3'b000, 1'b1, 1'b0);
      chk("lb_req", 32'(mem_req), 32'd1);
      chk("lb_we", 32'(mem_we), 32'd0);
      chk("lb_addr", mem_addr, 32'h8000_0000);
      mem_txn(32'h80FF_0000);
      chk("lb_out_valid", 32'(out_valid), 32'd1);
      chk("lb_rdata", MEM_Rdata, 32'hFFFF_FF80);
      chk("lb_mem_ren", 32'(mem_ren), 32'd1);
      tick();
      send(32'h8000_0003, 32'h0, 3'b100, 1'b1, 1'b0);
      mem_txn(32'h80FF_0000);
      chk("lbu_rdata", MEM_Rdata, 32'h0000_0080);
      tick();
      // sh at halfword 1
      send(32'h8000_0002, 32'hABCD_5678, 3'b001, 1'b0, 1'b1);
      chk("sh_we", 32'(mem_we), 32'd1);
      chk("sh_wmask", 32'(mem_wmask), 32'b1100);
      chk("sh_wdata", mem_wdata, 32'h5678_5678);
      chk("sh_addr", mem_addr, 32'h8000_0000);
      mem_txn(32'hDEAD_BEEF);
      chk("sh_rdata", MEM_Rdata, 32'd0);
      chk("sh_bus_err", 32'(bus_err), 32'd0);
      tick();
      // ren+wen sb with gnt and rvalid together
      send(32'h8000_0001, 32'h0000_00A5, 3'b000, 1'b1, 1'b1);
      chk("sb_we", 32'(mem_we), 32'd1);
      chk("sb_wmask", 32'(mem_wmask), 32'b0010);
      chk("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
      mem_gnt = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata = 32'h1234_5678;
      tick();
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      chk("sb_same_cycle_out", 32'(out_valid), 32'd1);
      chk("sb_mem_ren", 32'(mem_ren), 32'd0);
      chk("sb_rdata", MEM_Rdata, 32'd0);
      tick();
      // grant and writeback stalls
      out_ready = 1'b0;
      send(32'h8000_0010, 32'h0, 3'b010, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         chk("stall_req", 32'(mem_req), 32'd1);
         chk("stall_addr", mem_addr, 32'h8000_0010);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         tick();
      end
      mem_txn(32'h1122_3344);
      for (int i = 0; i < 3; i++) begin
         chk("hold_out_valid", 32'(out_valid), 32'd1);
         chk("hold_rdata", MEM_Rdata, 32'h1122_3344);
         chk("hold_in_ready", 32'(in_ready), 32'd0);
         chk("hold_req", 32'(mem_req), 32'd0);
         tick();
      end
      out_ready = 1'b1;
      chk("hold_release", 32'(out_valid), 32'd1);
      tick();
      chk("hold_idle", 32'(in_ready), 32'd1);
      // misaligned lw
      send(32'h8000_0002, 32'h0, 3'b010, 1'b1, 1'b0);
      chk("mis_req", 32'(mem_req), 32'd0);
      chk("mis_out_valid", 32'(out_valid), 32'd1);
      chk("mis_bus_err", 32'(bus_err), 32'd1);
      chk("mis_rdata", MEM_Rdata, 32'd0);
      tick();
      // timeout after 4 WAIT cycles
      send(32'h8000_0004, 32'h0, 3'b010, 1'b1, 1'b0);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("to_waiting", 32'(out_valid), 32'd0);
         tick();
      end
      chk("to_out_valid", 32'(out_valid), 32'd1);
      chk("to_bus_err", 32'(bus_err), 32'd1);
      chk("to_rdata", MEM_Rdata, 32'd0);
      tick();
      // reset during WAIT, then a stray response
      send(32'h8000_0008, 32'h0, 3'b010, 1'b1, 1'b0);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rw_in_ready", 32'(in_ready), 32'd1);
      chk("rw_out_valid", 32'(out_valid), 32'd0);
      chk("rw_req", 32'(mem_req), 32'd0);
      chk("rw_ex_result", Ex_result, 32'd0);
      mem_rvalid = 1'b1;
      mem_rdata = 32'h5555_AAAA;
      tick();
      mem_rvalid = 1'b0;
      chk("stray_out_valid", 32'(out_valid), 32'd0);
      chk("stray_rdata", MEM_Rdata, 32'd0);
      chk("stray_in_ready", 32'(in_ready), 32'd1);
      send(32'h8000_0002, 32'h0, 3'b001, 1'b1, 1'b0);
      chk("lh_req", 32'(mem_req), 32'd1);
      chk("lh_addr", mem_addr, 32'h8000_0000);
      mem_txn(32'h8001_2345);
      chk("lh_out_valid", 32'(out_valid), 32'd1);
      chk("lh_rdata", MEM_Rdata, 32'hFFFF_8001);
      tick();
      chk("lh_idle", 32'(in_ready), 32'd1);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
